// File: rtl/ramb16_loader_pkg.sv
// Shared definitions for the RAMB16 S36 loader.
// Contents:
//   - RAM word geometry: 32 data bits plus 4 parity bits.
//   - Loader FSM state enum.
//   - byte_parity(): one parity bit per byte, even or odd.
package ramb16_loader_pkg;

  localparam int RAM_DATA_W = 32;
  localparam int RAM_PAR_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_READ    = 3'd3,
    ST_CHECK   = 3'd4,
    ST_FINISH  = 3'd5
  } state_e;

  // Even parity is the XOR of the byte; odd parity is its complement.
  function automatic logic byte_parity(input logic [7:0] data, input logic odd);
    logic p;
    p = ^data;
    if (odd) begin
      return ~p;
    end else begin
      return p;
    end
  endfunction

endpackage

// File: rtl/ramb16_s36_loader_word_packer.sv
// s36_word_packer: packs four accepted bytes into one 36-bit RAM word.
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   clr           drop any partial word and restart at byte 0
//   byte_fire     a byte transfers this cycle (valid && ready)
//   byte_in       the byte being transferred
//   word_full     strobe: this transfer completes a word (4th byte)
//   word_di       packed data, byte n in bits [8n+7:8n]; held until overwritten
//   word_dip      parity, bit n covers byte n
module s36_word_packer
  import ramb16_loader_pkg::*;
#(
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  byte_fire,
  input  logic [7:0]            byte_in,
  output logic                  word_full,
  output logic [RAM_DATA_W-1:0] word_di,
  output logic [RAM_PAR_W-1:0]  word_dip
);

  localparam logic ODD = (PARITY_ODD != 0);

  logic [1:0]            idx_q, idx_d;
  logic [RAM_DATA_W-1:0] di_q, di_d;
  logic [RAM_PAR_W-1:0]  dip_q, dip_d;

  // Byte lane selection and parity generation for the next accepted byte.
  always_comb begin
    idx_d = idx_q;
    di_d  = di_q;
    dip_d = dip_q;
    if (clr) begin
      idx_d = 2'd0;
    end else if (byte_fire) begin
      di_d[{idx_q, 3'b000} +: 8] = byte_in;
      dip_d[idx_q]               = byte_parity(byte_in, ODD);
      idx_d                      = idx_q + 2'd1;
    end else begin
      idx_d = idx_q;
    end
  end

  // Index wraps 3 -> 0 on its own, so the next word starts at lane 0.
  assign word_full = byte_fire && !clr && (idx_q == 2'd3);
  assign word_di   = di_q;
  assign word_dip  = dip_q;

  // Packer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= 2'd0;
      di_q  <= '0;
      dip_q <= '0;
    end else begin
      idx_q <= idx_d;
      di_q  <= di_d;
      dip_q <= dip_d;
    end
  end

endmodule

// File: rtl/ramb16_s36_loader.sv
// ramb16_s36_loader: feeds a 512x36 block RAM from an 8-bit byte stream.
// A job writes COUNT packed words from BASE_ADDR upward (wrapping), or in
// verify mode reads them back and compares against the streamed bytes.
// Ports:
//   CLK, RST             clock and synchronous active-high reset
//   START/VERIFY/BASE_ADDR/COUNT   job request, sampled only when idle
//   BYTE_IN/BYTE_VALID/BYTE_READY  byte stream handshake
//   RAM_ADDR/RAM_DI/RAM_DIP/RAM_EN/RAM_WE/RAM_DO/RAM_DOP  RAM port
//   BUSY/DONE            job in progress / one-cycle completion pulse
//   ERROR/ERR_ADDR       sticky verify mismatch and first failing address
module ramb16_s36_loader
  import ramb16_loader_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int PARITY_ODD = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  VERIFY,
  input  logic [ADDR_W-1:0]     BASE_ADDR,
  input  logic [ADDR_W:0]       COUNT,
  input  logic [7:0]            BYTE_IN,
  input  logic                  BYTE_VALID,
  output logic                  BYTE_READY,
  output logic [ADDR_W-1:0]     RAM_ADDR,
  output logic [RAM_DATA_W-1:0] RAM_DI,
  output logic [RAM_PAR_W-1:0]  RAM_DIP,
  output logic                  RAM_EN,
  output logic                  RAM_WE,
  input  logic [RAM_DATA_W-1:0] RAM_DO,
  input  logic [RAM_PAR_W-1:0]  RAM_DOP,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERROR,
  output logic [ADDR_W-1:0]     ERR_ADDR
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};

  state_e              state_q, state_d;
  logic                verify_q, verify_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic                ready_q, ready_d;
  logic                en_q, en_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                  start_acc_s;
  logic                  byte_fire_s;
  logic                  word_full_s;
  logic [RAM_DATA_W-1:0] word_di_s;
  logic [RAM_PAR_W-1:0]  word_dip_s;
  logic                  mismatch_s;

  assign start_acc_s = START && (state_q == ST_IDLE);
  // ready_q mirrors "state is COLLECT", so this is the handshake itself.
  assign byte_fire_s = BYTE_VALID && ready_q;
  assign mismatch_s  = ({RAM_DOP, RAM_DO} != {word_dip_s, word_di_s});

  s36_word_packer #(
    .PARITY_ODD (PARITY_ODD)
  ) u_packer (
    .clk       (CLK),
    .rst       (RST),
    .clr       (start_acc_s),
    .byte_fire (byte_fire_s),
    .byte_in   (BYTE_IN),
    .word_full (word_full_s),
    .word_di   (word_di_s),
    .word_dip  (word_dip_s)
  );

  // Next-state, job bookkeeping and registered output decode.
  always_comb begin
    state_d    = state_q;
    verify_d   = verify_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          verify_d   = VERIFY;
          addr_d     = BASE_ADDR;
          cnt_d      = COUNT;
          err_d      = 1'b0;
          err_addr_d = '0;
          if (COUNT == CNT_ZERO) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (word_full_s) begin
          state_d = verify_q ? ST_READ : ST_WRITE;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + ADDR_ONE;
        cnt_d   = cnt_q - CNT_ONE;
        state_d = (cnt_q == CNT_ONE) ? ST_FINISH : ST_COLLECT;
      end
      ST_READ: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        // addr_q still holds the address read in the previous cycle.
        if (mismatch_s && !err_q) begin
          err_d      = 1'b1;
          err_addr_d = addr_q;
        end else begin
          err_d      = err_q;
          err_addr_d = err_addr_q;
        end
        addr_d  = addr_q + ADDR_ONE;
        cnt_d   = cnt_q - CNT_ONE;
        state_d = (cnt_q == CNT_ONE) ? ST_FINISH : ST_COLLECT;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they align with state_q.
    ready_d = (state_d == ST_COLLECT);
    en_d    = (state_d == ST_WRITE) || (state_d == ST_READ);
    we_d    = (state_d == ST_WRITE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_FINISH);
  end

  // State, job and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      verify_q   <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      ready_q    <= 1'b0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      verify_q   <= verify_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      ready_q    <= ready_d;
      en_q       <= en_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign BYTE_READY = ready_q;
  assign RAM_ADDR   = addr_q;
  assign RAM_DI     = word_di_s;
  assign RAM_DIP    = word_dip_s;
  assign RAM_EN     = en_q;
  assign RAM_WE     = we_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ERROR      = err_q;
  assign ERR_ADDR   = err_addr_q;

endmodule

// File: tb/tb_ramb16_s36_loader.sv
module tb_ramb16_s36_loader;

  localparam int DEPTH = 512;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        VERIFY = 1'b0;
  logic [8:0]  BASE_ADDR = 9'd0;
  logic [9:0]  COUNT = 10'd0;
  logic [7:0]  BYTE_IN = 8'd0;
  logic        BYTE_VALID = 1'b0;
  logic        BYTE_READY;
  logic [8:0]  RAM_ADDR;
  logic [31:0] RAM_DI;
  logic [3:0]  RAM_DIP;
  logic        RAM_EN;
  logic        RAM_WE;
  logic [31:0] ram_do;
  logic [3:0]  ram_dop;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;
  logic [8:0]  ERR_ADDR;

  always #5 CLK = ~CLK;

  ramb16_s36_loader dut (
    .CLK(CLK), .RST(RST), .START(START), .VERIFY(VERIFY),
    .BASE_ADDR(BASE_ADDR), .COUNT(COUNT),
    .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID), .BYTE_READY(BYTE_READY),
    .RAM_ADDR(RAM_ADDR), .RAM_DI(RAM_DI), .RAM_DIP(RAM_DIP),
    .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_DO(ram_do), .RAM_DOP(ram_dop),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .ERR_ADDR(ERR_ADDR)
  );

  typedef struct {
    logic [8:0]  addr;
    logic        we;
    logic [31:0] di;
    logic [3:0]  dip;
  } op_t;

  typedef struct {
    logic       err;
    logic [8:0] ea;
  } done_t;

  op_t         exp_ops[$];
  done_t       exp_done[$];
  op_t         mon_op;
  done_t       mon_done;
  logic [35:0] mem [0:DEPTH-1];
  logic [35:0] ref_ram [0:DEPTH-1];
  logic        mem_init = 1'b0;
  logic        corrupt_en = 1'b0;
  logic [8:0]  corrupt_addr = 9'd0;
  logic [7:0]  jb[$];
  logic        prev_done;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Behavioural block RAM, 1-cycle synchronous read.
  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 36'h0;
    end else if (corrupt_en) begin
      mem[corrupt_addr] <= mem[corrupt_addr] ^ 36'h1;
    end else if (RAM_EN && RAM_WE) begin
      mem[RAM_ADDR] <= {RAM_DIP, RAM_DI};
    end else if (RAM_EN) begin
      {ram_dop, ram_do} <= mem[RAM_ADDR];
    end
  end

  // Monitor: compares every RAM access and every DONE against the scoreboard.
  always @(negedge CLK) begin
    if (RST) begin
      prev_done <= 1'b0;
    end else begin
      if (prev_done) check("busy_after_done", BUSY, 0);
      if (RAM_WE && !RAM_EN) fail_now("ram_we_without_en");
      if (RAM_EN) begin
        if (exp_ops.size() == 0) begin
          fail_now($sformatf("unexpected_ram_access addr=0x%0h we=%0d", RAM_ADDR, RAM_WE));
        end else begin
          mon_op = exp_ops.pop_front();
          check("ram_addr", RAM_ADDR, mon_op.addr);
          check("ram_we", RAM_WE, mon_op.we);
          check("ram_di", RAM_DI, mon_op.di);
          check("ram_dip", RAM_DIP, mon_op.dip);
        end
      end
      if (DONE) begin
        if (exp_done.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          mon_done = exp_done.pop_front();
          check("done_error", ERROR, mon_done.err);
          check("done_err_addr", ERR_ADDR, mon_done.ea);
        end
      end
      prev_done <= DONE;
    end
  end

  // Reference model: expected RAM accesses and completion status of one job.
  task automatic model_job(input bit verify, input int base, input int count);
    done_t       d;
    op_t         o;
    logic [31:0] word;
    logic [3:0]  par;
    d.err = 1'b0;
    d.ea  = 9'd0;
    for (int w = 0; w < count; w++) begin
      word = 32'd0;
      par  = 4'd0;
      for (int k = 0; k < 4; k++) begin
        word   = word + (32'(jb[4*w+k]) << (8*k));
        par[k] = (($countones(jb[4*w+k]) % 2) == 1);
      end
      o.addr = 9'((base + w) % DEPTH);
      o.we   = !verify;
      o.di   = word;
      o.dip  = par;
      exp_ops.push_back(o);
      if (!verify) begin
        ref_ram[o.addr] = {par, word};
      end else if (ref_ram[o.addr] != {par, word} && !d.err) begin
        d.err = 1'b1;
        d.ea  = o.addr;
      end
    end
    exp_done.push_back(d);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (BUSY && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (BUSY) fail_now("wait_idle_timeout");
  endtask

  task automatic start_job(input bit verify, input int base, input int count);
    @(negedge CLK);
    START = 1'b1;
    VERIFY = verify;
    BASE_ADDR = 9'(base);
    COUNT = 10'(count);
    @(negedge CLK);
    START = 1'b0;
    VERIFY = 1'b0;
  endtask

  task automatic feed(input int nbytes, input bit rnd, input bit poke);
    int i;
    int guard;
    bit poked;
    i = 0;
    guard = 0;
    poked = 0;
    while (i < nbytes && guard < 5000) begin
      START = 1'b0;
      BYTE_IN = jb[i];
      BYTE_VALID = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (poke && !poked && i == 2) begin
        START = 1'b1;
        VERIFY = 1'b1;
        BASE_ADDR = 9'($urandom);
        COUNT = 10'd0;
        poked = 1;
      end
      if (BYTE_VALID && BYTE_READY) i++;
      @(negedge CLK);
      guard++;
    end
    START = 1'b0;
    VERIFY = 1'b0;
    BYTE_VALID = 1'b0;
    if (i < nbytes) fail_now("feed_timeout");
  endtask

  task automatic run_job(input bit verify, input int base, input int count,
                         input bit rnd, input bit poke);
    wait_idle();
    model_job(verify, base, count);
    start_job(verify, base, count);
    feed(4 * count, rnd, poke);
    wait_idle();
    @(negedge CLK);
  endtask

  task automatic rand_bytes(input int n);
    jb.delete();
    for (int i = 0; i < n; i++) jb.push_back(8'($urandom));
  endtask

  initial begin
    int b;
    int c;
    for (int i = 0; i < DEPTH; i++) ref_ram[i] = 36'h0;
    RST = 1'b1;
    mem_init = 1'b1;
    repeat (3) @(negedge CLK);
    mem_init = 1'b0;
    check("rst_byte_ready", BYTE_READY, 0);
    check("rst_ram_en", RAM_EN, 0);
    check("rst_ram_we", RAM_WE, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_error", ERROR, 0);
    check("rst_err_addr", ERR_ADDR, 0);
    check("rst_ram_addr", RAM_ADDR, 0);
    check("rst_ram_di", RAM_DI, 0);
    check("rst_ram_dip", RAM_DIP, 0);
    RST = 1'b0;
    @(negedge CLK);

    // 1: single word, fixed bytes
    jb.delete();
    jb.push_back(8'h11); jb.push_back(8'h22); jb.push_back(8'h33); jb.push_back(8'h44);
    run_job(0, 0, 1, 0, 0);

    // 2: address wrap-around
    rand_bytes(12);
    run_job(0, 9'h1FE, 3, 1, 0);

    // 3: clean verify
    rand_bytes(16);
    run_job(0, 9'h040, 4, 1, 0);
    run_job(1, 9'h040, 4, 1, 0);

    // 4: verify with words 1 and 2 corrupted
    rand_bytes(16);
    run_job(0, 9'h010, 4, 0, 0);
    @(negedge CLK);
    corrupt_en = 1'b1;
    corrupt_addr = 9'h011;
    ref_ram[9'h011] = ref_ram[9'h011] ^ 36'h1;
    @(negedge CLK);
    corrupt_addr = 9'h012;
    ref_ram[9'h012] = ref_ram[9'h012] ^ 36'h1;
    @(negedge CLK);
    corrupt_en = 1'b0;
    run_job(1, 9'h010, 4, 1, 0);
    repeat (5) @(negedge CLK);
    check("sticky_error", ERROR, 1);
    check("sticky_err_addr", ERR_ADDR, 9'h011);

    // 5: random stalls plus START while busy
    rand_bytes(20);
    b = $urandom_range(0, DEPTH - 1);
    run_job(0, b, 5, 1, 1);
    run_job(1, b, 5, 1, 1);

    // random write/verify pairs
    for (int r = 0; r < 3; r++) begin
      b = $urandom_range(0, DEPTH - 1);
      c = $urandom_range(1, 6);
      rand_bytes(4 * c);
      run_job(0, b, c, 1, 0);
      run_job(1, b, c, 1, 0);
    end

    // 6: reset after two bytes of a word
    wait_idle();
    jb.delete();
    jb.push_back(8'h5A); jb.push_back(8'hC3);
    start_job(0, 5, 1);
    feed(2, 0, 0);
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_ram_en", RAM_EN, 0);
    check("midrst_ram_we", RAM_WE, 0);
    check("midrst_busy", BUSY, 0);
    check("midrst_byte_ready", BYTE_READY, 0);
    RST = 1'b0;
    @(negedge CLK);
    jb.delete();
    jb.push_back(8'hAA); jb.push_back(8'hBB); jb.push_back(8'hCC); jb.push_back(8'hDD);
    run_job(0, 5, 1, 0, 0);
    run_job(0, 9'h100, 0, 0, 0);

    repeat (4) @(negedge CLK);
    check("ops_left", exp_ops.size(), 0);
    check("done_left", exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
